// File: rtl/risc240_step_ctrl_pkg.sv
// Purpose: shared run-control state encoding and constants for the RISC240 step controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package risc240_step_ctrl_pkg;

    // Run-control states. HALT is the reset state.
    typedef enum logic [2:0] {
        HALT   = 3'd0,
        STEP   = 3'd1,
        RUN    = 3'd2,
        BREAK  = 3'd3,
        RESUME = 3'd4
    } step_state_t;

    localparam logic [31:0] CYCLE_COUNT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == CYCLE_COUNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/risc240_step_ctrl_key_debounce.sv
// Purpose: synchronize and debounce the raw step pushbutton; emit a one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 registered pulse cycle.
// Backpressure: none; a press is a single pulse and is lost if the consumer ignores it.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset_L,
    input  logic key_raw_L,
    output logic key_level,
    output logic press
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic [15:0] cnt_q,   cnt_d;

    // Sync pipeline, stability counter, level acceptance and press edge detection.
    always_comb begin
        sync1_d = key_raw_L;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = 16'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                // Input has differed long enough: take the new level.
                // Only the released->pressed transition produces a pulse.
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Register bank; everything resets to the released level.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level = level_q;
    assign press     = press_q;

endmodule

// File: rtl/risc240_step_ctrl.sv
// Purpose: single-step / free-run / breakpoint clock-enable controller for the RISC240 core.
// Latency: run_sw acts 2 cycles after sync; breakpoint and run-stop exits gate cpu_clk_en in the same cycle.
// Backpressure: none; presses arriving outside HALT/BREAK are dropped, not queued.
module risc240_step_ctrl
    import risc240_step_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        step_key_L,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] pc,
    input  logic        at_fetch,
    output logic        cpu_clk_en,
    output logic        halted,
    output logic        at_break,
    output logic [31:0] cycle_count
);

    step_state_t state_q, state_d;
    logic        run_sync1_q, run_sync1_d;
    logic        run_sync2_q, run_sync2_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        press;
    logic        key_level_unused;
    logic        bp_hit;
    logic        clk_en;
    logic        halted_o;
    logic        at_break_o;

    // Accepted key level is kept on a named net so it is easy to probe on a board.
    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock     (clock),
        .reset_L   (reset_L),
        .key_raw_L (step_key_L),
        .key_level (key_level_unused),
        .press     (press)
    );

    // Breakpoint matches only at the first fetch state so it stops before the instruction.
    assign bp_hit = bp_en && at_fetch && (pc == bp_addr);

    // Next-state and Moore decodes; RUN additionally gates its own exit cycle.
    always_comb begin
        state_d    = state_q;
        clk_en     = 1'b0;
        halted_o   = 1'b0;
        at_break_o = 1'b0;
        case (state_q)
            HALT: begin
                halted_o = 1'b1;
                if (run_sync2_q) begin
                    state_d = RUN;
                end else if (press) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                clk_en  = 1'b1;
                state_d = HALT;
            end
            RUN: begin
                // Stop request outranks the breakpoint; either one withholds this cycle's enable.
                if (!run_sync2_q) begin
                    state_d = HALT;
                end else if (bp_hit) begin
                    state_d = BREAK;
                end else begin
                    clk_en = 1'b1;
                end
            end
            BREAK: begin
                halted_o   = 1'b1;
                at_break_o = 1'b1;
                if (!run_sync2_q) begin
                    state_d = HALT;
                end else if (press) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                // One unconditional cycle lets the core move past the breakpoint address.
                clk_en  = 1'b1;
                state_d = run_sync2_q ? RUN : HALT;
            end
            default: begin
                halted_o = 1'b1;
                state_d  = HALT;
            end
        endcase
    end

    // State register; reset drops straight to HALT, which kills cpu_clk_en immediately.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // run_sw synchronizer input and saturating enabled-cycle counter.
    always_comb begin
        run_sync1_d   = run_sw;
        run_sync2_d   = run_sync1_q;
        cycle_count_d = clk_en ? sat_inc32(cycle_count_q) : cycle_count_q;
    end

    // Synchronizer and counter registers; run request resets to "not running".
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            run_sync1_q   <= 1'b0;
            run_sync2_q   <= 1'b0;
            cycle_count_q <= 32'd0;
        end else begin
            run_sync1_q   <= run_sync1_d;
            run_sync2_q   <= run_sync2_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cpu_clk_en  = clk_en;
    assign halted      = halted_o;
    assign at_break    = at_break_o;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_risc240_step_ctrl.sv
// Purpose: directed self-checking bench for risc240_step_ctrl with a short debounce window.
// Latency: outputs sampled on the falling edge, inputs changed on the falling edge.
// Backpressure: n/a.
module tb_risc240_step_ctrl;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        step_key_L;
    logic        run_sw;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] pc;
    logic        at_fetch;
    logic        cpu_clk_en;
    logic        halted;
    logic        at_break;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    risc240_step_ctrl #(
        .DEBOUNCE_CYCLES (16'd4)
    ) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .step_key_L  (step_key_L),
        .run_sw      (run_sw),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .at_fetch    (at_fetch),
        .cpu_clk_en  (cpu_clk_en),
        .halted      (halted),
        .at_break    (at_break),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        step_key_L = 1'b1;
        run_sw     = 1'b0;
        bp_en      = 1'b0;
        bp_addr    = 16'h0000;
        pc         = 16'h0000;
        at_fetch   = 1'b0;
        @(negedge clock);
        reset_L = 1'b0;
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        reset_L = 1'b0;
        #1;
        checks++;
        if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b expected 0", cpu_clk_en); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", halted); end
        checks++;
        if (at_break !== 1'b0) begin errors++; $display("FAIL reset_at_break: got %b expected 0", at_break); end
        checks++;
        if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", cycle_count); end
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    // Key held 10 cycles: press accepted after 2 sync + 4 stable cycles, STEP on sample 6.
    task automatic test_single_step();
        int pulses = 0;
        int pos = -1;
        do_reset();
        @(negedge clock);
        step_key_L = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) begin pulses++; pos = i; end
        end
        step_key_L = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL step_pulses: got %0d expected 1", pulses); end
        checks++;
        if (pos != 6) begin errors++; $display("FAIL step_position: got %0d expected 6", pos); end
        checks++;
        if (cycle_count !== 32'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", cycle_count); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL step_halted: got %b expected 1", halted); end
    endtask

    // Bouncing key (2 low / 2 high) never stays stable for 4 cycles: no press at all.
    task automatic test_bounce();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) pulses++;
            step_key_L = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
        end
        step_key_L = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", pulses); end
        checks++;
        if (cycle_count !== 32'd0) begin errors++; $display("FAIL bounce_count: got %0d expected 0", cycle_count); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL bounce_halted: got %b expected 1", halted); end
    endtask

    // Free run for 20 cycles: enable from sample 2, one extra cycle after the fall, then off.
    task automatic test_run();
        int pulses = 0;
        int bad = 0;
        do_reset();
        @(negedge clock);
        run_sw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) pulses++;
            if (cpu_clk_en !== ((i >= 2) ? 1'b1 : 1'b0)) bad++;
        end
        run_sw = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) pulses++;
            if (cpu_clk_en !== ((j == 0) ? 1'b1 : 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL run_enable_shape: got %0d wrong samples expected 0", bad); end
        checks++;
        if (pulses != 19) begin errors++; $display("FAIL run_pulses: got %0d expected 19", pulses); end
        checks++;
        if (cycle_count !== 32'd19) begin errors++; $display("FAIL run_count: got %0d expected 19", cycle_count); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL run_halted: got %b expected 1", halted); end
    endtask

    // Breakpoint hit, then press resumes one cycle past it; the core leaves fetch so no re-break.
    task automatic test_breakpoint();
        int pos = -1;
        int runs = 0;
        do_reset();
        bp_en    = 1'b1;
        bp_addr  = 16'h0010;
        pc       = 16'h0000;
        at_fetch = 1'b1;
        @(negedge clock);
        run_sw = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (cpu_clk_en !== 1'b1) begin errors++; $display("FAIL bp_running: got %b expected 1", cpu_clk_en); end
        pc = 16'h0010;
        #1;
        checks++;
        if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_gate: got %b expected 0", cpu_clk_en); end
        @(negedge clock);
        checks++;
        if ({cpu_clk_en, halted, at_break} !== 3'b011) begin
            errors++; $display("FAIL bp_break_state: got en/halt/brk %b expected 011", {cpu_clk_en, halted, at_break});
        end
        step_key_L = 1'b0;
        for (int i = 0; i < 15 && pos < 0; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1) begin
                pos = i;
                checks++;
                if ({halted, at_break} !== 2'b00) begin
                    errors++; $display("FAIL bp_resume_flags: got halt/brk %b expected 00", {halted, at_break});
                end
                at_fetch   = 1'b0;
                step_key_L = 1'b1;
            end
        end
        checks++;
        if (pos != 6) begin errors++; $display("FAIL bp_resume_position: got %0d expected 6", pos); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (cpu_clk_en === 1'b1 && at_break === 1'b0) runs++;
        end
        checks++;
        if (runs != 5) begin errors++; $display("FAIL bp_no_rebreak: got %0d running cycles expected 5", runs); end
        run_sw = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Reset mid-RUN at count 7: enable drops at once, RUN returns 2 cycles after release.
    task automatic test_reset_in_run();
        int waited = 0;
        do_reset();
        @(negedge clock);
        run_sw = 1'b1;
        while (cycle_count !== 32'd7 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (cycle_count !== 32'd7) begin errors++; $display("FAIL rr_reach_7: got %0d expected 7", cycle_count); end
        reset_L = 1'b0;
        #1;
        checks++;
        if ({cpu_clk_en, halted, at_break} !== 3'b010) begin
            errors++; $display("FAIL rr_reset_flags: got en/halt/brk %b expected 010", {cpu_clk_en, halted, at_break});
        end
        checks++;
        if (cycle_count !== 32'd0) begin errors++; $display("FAIL rr_reset_count: got %0d expected 0", cycle_count); end
        @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({cpu_clk_en, halted} !== 2'b01) begin
            errors++; $display("FAIL rr_sync_latency: got en/halt %b expected 01", {cpu_clk_en, halted});
        end
        @(negedge clock);
        checks++;
        if ({cpu_clk_en, halted} !== 2'b10) begin
            errors++; $display("FAIL rr_resumed: got en/halt %b expected 10", {cpu_clk_en, halted});
        end
        run_sw = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Counter preloaded to FFFF_FFFD in HALT, then RUN: steps to FFFF_FFFF and sticks.
    task automatic test_saturate();
        logic [31:0] exp_cnt;
        int bad = 0;
        do_reset();
        @(negedge clock);
        force dut.cycle_count_q = 32'hFFFF_FFFD;
        @(negedge clock);
        release dut.cycle_count_q;
        run_sw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            exp_cnt = (i <= 2) ? 32'hFFFF_FFFD : ((i == 3) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            if (cycle_count !== exp_cnt) begin
                bad++;
                $display("FAIL sat_count[%0d]: got %h expected %h", i, cycle_count, exp_cnt);
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sat_sequence: got %0d wrong samples expected 0", bad); end
        checks++;
        if (cpu_clk_en !== 1'b1) begin errors++; $display("FAIL sat_still_running: got %b expected 1", cpu_clk_en); end
        run_sw = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (cycle_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffffffff", cycle_count); end
    endtask

    initial begin
        reset_L    = 1'b0;
        step_key_L = 1'b1;
        run_sw     = 1'b0;
        bp_en      = 1'b0;
        bp_addr    = 16'h0000;
        pc         = 16'h0000;
        at_fetch   = 1'b0;
        test_reset();
        test_single_step();
        test_bounce();
        test_run();
        test_breakpoint();
        test_reset_in_run();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
